// File: rtl/dbg_trig_gen_pkg.sv
// ---------------------------------------------------------------------------
// dbg_trig_pkg
// Shared types and constants for the debug trigger conditioner:
//   - one-hot FSM state encoding and the flop index of each state bit
//   - bit positions inside the 8-bit trg vector driven into ILA TRIG0
//   - saturating 8-bit increment used by the fire counter
// ---------------------------------------------------------------------------
package dbg_trig_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ARMED = 4'b0010,
    ST_FIRE  = 4'b0100,
    ST_HOLD  = 4'b1000
  } state_e;

  // Flop index of each one-hot state bit, so trg can be taken straight from flops
  localparam int unsigned ST_ARMED_BIT = 1;
  localparam int unsigned ST_FIRE_BIT  = 2;
  localparam int unsigned ST_HOLD_BIT  = 3;

  // trg bit positions
  localparam int unsigned TRG_FIRE      = 0;
  localparam int unsigned TRG_MATCH     = 1;
  localparam int unsigned TRG_ARMED     = 2;
  localparam int unsigned TRG_HOLD      = 3;
  localparam int unsigned TRG_PROBE_LSB = 4;

  // Increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = val;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dbg_trig_gen_if.sv
// ---------------------------------------------------------------------------
// dbg_trig_gen_if
// Groups the probe/configuration/control inputs and the trigger outputs of
// dbg_trig_gen.
//   master : drives probe, mask, pattern, edge_sel, count_target, holdoff,
//            auto_rearm, arm, disarm; observes trg, fire_count
//   slave  : the trigger conditioner itself
// ---------------------------------------------------------------------------
interface dbg_trig_gen_if;

  logic [7:0]  probe;
  logic [7:0]  mask;
  logic [7:0]  pattern;
  logic [7:0]  edge_sel;
  logic [7:0]  count_target;
  logic [15:0] holdoff;
  logic        auto_rearm;
  logic        arm;
  logic        disarm;
  logic [7:0]  trg;
  logic [7:0]  fire_count;

  modport master (
    output probe, mask, pattern, edge_sel, count_target, holdoff,
           auto_rearm, arm, disarm,
    input  trg, fire_count
  );

  modport slave (
    input  probe, mask, pattern, edge_sel, count_target, holdoff,
           auto_rearm, arm, disarm,
    output trg, fire_count
  );

endinterface

// File: rtl/dbg_trig_gen_match.sv
// ---------------------------------------------------------------------------
// dbg_trig_match
// Input stage of the trigger conditioner: two probe flops, per-bit level or
// edge compare against pattern, AND over masked bits, registered result.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   probe[7:0]        : design signals under observation
//   mask[7:0]         : 1 = bit takes part in the match
//   pattern[7:0]      : required value per masked bit
//   edge_sel[7:0]     : 1 = bit matches only on a transition into pattern
//   match_q           : registered match (one cycle after probe_q)
//   probe_q[7:0]      : first probe flop, also exported for trg[7:4]
// ---------------------------------------------------------------------------
module dbg_trig_match (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] probe,
  input  logic [7:0] mask,
  input  logic [7:0] pattern,
  input  logic [7:0] edge_sel,
  output logic       match_q,
  output logic [7:0] probe_q
);

  logic [7:0] probe_q_r;
  logic [7:0] probe_d_r;
  logic       match_q_r;
  logic [7:0] level_s;
  logic [7:0] edge_s;
  logic [7:0] cond_s;
  logic       match_s;

  // Per-bit compare; unmasked bits are forced true, an empty mask never matches
  always_comb begin
    level_s = ~(probe_q_r ^ pattern);
    edge_s  = level_s & (probe_d_r ^ probe_q_r);
    cond_s  = (edge_sel & edge_s) | (~edge_sel & level_s);
    if (mask == 8'h00) begin
      match_s = 1'b0;
    end else begin
      match_s = ((cond_s | ~mask) == 8'hFF);
    end
  end

  // Probe pipeline and registered match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_q_r <= 8'h00;
      probe_d_r <= 8'h00;
      match_q_r <= 1'b0;
    end else begin
      probe_q_r <= probe;
      probe_d_r <= probe_q_r;
      match_q_r <= match_s;
    end
  end

  assign match_q = match_q_r;
  assign probe_q = probe_q_r;

endmodule

// File: rtl/dbg_trig_gen.sv
// ---------------------------------------------------------------------------
// dbg_trig_gen
// Debug trigger conditioner feeding ILA TRIG0. Counts qualifying probe
// matches while ARMED, emits a STRETCH-cycle fire pulse, then an optional
// hold-off before re-arming (auto_rearm) or returning to IDLE.
// Ports:
//   clk, rst_n : clock (same as ILA), asynchronous active-low reset
//   bus        : dbg_trig_gen_if.slave
//                in : probe, mask, pattern, edge_sel, count_target (latched
//                     on arm, 0 means 1), holdoff (latched on arm),
//                     auto_rearm, arm, disarm
//                out: trg[0] fire, trg[1] match_q, trg[2] armed,
//                     trg[3] hold-off, trg[7:4] probe_q[3:0];
//                     fire_count (fires since last arm, saturating)
// Parameter:
//   STRETCH    : fire pulse width in cycles, 1..255
// ---------------------------------------------------------------------------
module dbg_trig_gen
  import dbg_trig_pkg::*;
#(
  parameter int unsigned STRETCH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dbg_trig_gen_if.slave bus
);

  localparam logic [7:0] STRETCH_M1 = 8'(STRETCH - 1);

  state_e      state_r;
  logic [7:0]  match_cnt_r;
  logic [7:0]  target_lat_r;
  logic [7:0]  str_cnt_r;
  logic [7:0]  fire_count_r;
  logic [15:0] hold_cnt_r;
  logic [15:0] holdoff_lat_r;
  logic        settle_r;
  logic        match_q_s;
  logic [7:0]  probe_q_s;
  logic        hit_s;
  logic [7:0]  trg_s;

  dbg_trig_match u_match (
    .clk      (clk),
    .rst_n    (rst_n),
    .probe    (bus.probe),
    .mask     (bus.mask),
    .pattern  (bus.pattern),
    .edge_sel (bus.edge_sel),
    .match_q  (match_q_s),
    .probe_q  (probe_q_s)
  );

  // This match reaches the latched target
  always_comb begin
    hit_s = (({1'b0, match_cnt_r} + 9'd1) >= {1'b0, target_lat_r});
  end

  // Trigger FSM and its counters. After any re-arm the first ARMED cycle is a
  // settle cycle: its match_q reflects a probe sampled during the dead time,
  // which must not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      match_cnt_r   <= 8'd0;
      target_lat_r  <= 8'd0;
      str_cnt_r     <= 8'd0;
      fire_count_r  <= 8'd0;
      hold_cnt_r    <= 16'd0;
      holdoff_lat_r <= 16'd0;
      settle_r      <= 1'b0;
    end else if (bus.disarm) begin
      state_r     <= ST_IDLE;
      match_cnt_r <= 8'd0;
      str_cnt_r   <= 8'd0;
      hold_cnt_r  <= 16'd0;
      settle_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.arm) begin
            state_r       <= ST_ARMED;
            target_lat_r  <= (bus.count_target == 8'd0) ? 8'd1 : bus.count_target;
            holdoff_lat_r <= bus.holdoff;
            match_cnt_r   <= 8'd0;
            fire_count_r  <= 8'd0;
            settle_r      <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (settle_r) begin
            settle_r <= 1'b0;
          end else if (match_q_s && hit_s) begin
            state_r      <= ST_FIRE;
            match_cnt_r  <= 8'd0;
            str_cnt_r    <= 8'd0;
            fire_count_r <= sat_inc8(fire_count_r);
          end else if (match_q_s) begin
            match_cnt_r <= match_cnt_r + 8'd1;
          end else begin
            state_r <= ST_ARMED;
          end
        end
        ST_FIRE: begin
          if (str_cnt_r == STRETCH_M1) begin
            str_cnt_r <= 8'd0;
            if (holdoff_lat_r != 16'd0) begin
              state_r    <= ST_HOLD;
              hold_cnt_r <= 16'd0;
            end else if (bus.auto_rearm) begin
              state_r     <= ST_ARMED;
              match_cnt_r <= 8'd0;
              settle_r    <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            str_cnt_r <= str_cnt_r + 8'd1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_r == (holdoff_lat_r - 16'd1)) begin
            hold_cnt_r <= 16'd0;
            if (bus.auto_rearm) begin
              state_r     <= ST_ARMED;
              match_cnt_r <= 8'd0;
              settle_r    <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          match_cnt_r <= 8'd0;
          str_cnt_r   <= 8'd0;
          hold_cnt_r  <= 16'd0;
          settle_r    <= 1'b0;
        end
      endcase
    end
  end

  // trg taken straight from flops: one-hot state bits, match_q, probe_q
  always_comb begin
    trg_s                          = 8'h00;
    trg_s[TRG_FIRE]                = state_r[ST_FIRE_BIT];
    trg_s[TRG_MATCH]               = match_q_s;
    trg_s[TRG_ARMED]               = state_r[ST_ARMED_BIT];
    trg_s[TRG_HOLD]                = state_r[ST_HOLD_BIT];
    trg_s[TRG_PROBE_LSB +: 4]      = probe_q_s[3:0];
  end

  assign bus.trg        = trg_s;
  assign bus.fire_count = fire_count_r;

endmodule

// File: tb/tb_dbg_trig_gen.sv
module tb_dbg_trig_gen;

  localparam int STRETCH = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dbg_trig_gen_if bus ();

  dbg_trig_gen #(.STRETCH(STRETCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec;
  int n_err;

  // Reference model: probe history, match flag, mode with remaining-cycle countdown
  logic [7:0] m_pq, m_pd;
  logic       m_mq;
  int         m_mode;   // 0 idle, 1 armed, 2 fire, 3 hold-off
  int         m_left, m_hits, m_need, m_gap, m_fires;
  bit         m_settle;
  logic [7:0] exp_trg, exp_fc;

  function automatic bit model_match(logic [7:0] q, logic [7:0] d, logic [7:0] mk,
                                     logic [7:0] pat, logic [7:0] es);
    int used;
    bit ok;
    used = 0;
    ok   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (mk[i]) begin
        used++;
        if (q[i] !== pat[i]) ok = 1'b0;
        else if (es[i] && (d[i] === q[i])) ok = 1'b0;
      end
    end
    return (used > 0) && ok;
  endfunction

  function void model_reset();
    m_pq = 8'h00; m_pd = 8'h00; m_mq = 1'b0;
    m_mode = 0; m_left = 0; m_hits = 0; m_need = 0; m_gap = 0; m_fires = 0;
    m_settle = 1'b0;
  endfunction

  function void model_leave();
    if (bus.auto_rearm) begin
      m_mode = 1; m_hits = 0; m_settle = 1'b1;
    end else begin
      m_mode = 0;
    end
  endfunction

  function void model_step();
    bit nm;
    nm = model_match(m_pq, m_pd, bus.mask, bus.pattern, bus.edge_sel);
    if (bus.disarm) begin
      m_mode = 0; m_hits = 0; m_settle = 1'b0;
    end else begin
      case (m_mode)
        0: if (bus.arm) begin
             m_mode = 1;
             m_need = (bus.count_target == 8'd0) ? 1 : int'(bus.count_target);
             m_gap  = int'(bus.holdoff);
             m_hits = 0; m_fires = 0; m_settle = 1'b0;
           end
        1: if (m_settle) m_settle = 1'b0;
           else if (m_mq) begin
             m_hits++;
             if (m_hits >= m_need) begin
               m_mode = 2; m_left = STRETCH; m_hits = 0;
               if (m_fires < 255) m_fires++;
             end
           end
        2: begin
             m_left--;
             if (m_left == 0) begin
               if (m_gap != 0) begin m_mode = 3; m_left = m_gap; end
               else model_leave();
             end
           end
        3: begin
             m_left--;
             if (m_left == 0) model_leave();
           end
        default: m_mode = 0;
      endcase
    end
    m_pd = m_pq;
    m_pq = bus.probe;
    m_mq = nm;
    exp_trg = {m_pq[3:0], (m_mode == 3), (m_mode == 1), m_mq, (m_mode == 2)};
    exp_fc  = 8'(m_fires);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_cfg(logic [7:0] mk, logic [7:0] pat, logic [7:0] es,
                         logic [7:0] ct, logic [15:0] ho, logic ar);
    bus.mask = mk; bus.pattern = pat; bus.edge_sel = es;
    bus.count_target = ct; bus.holdoff = ho; bus.auto_rearm = ar;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.probe = 8'h00; bus.arm = 1'b0; bus.disarm = 1'b0;
    set_cfg(8'h00, 8'h00, 8'h00, 8'd0, 16'd0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.trg !== 8'h00 || bus.fire_count !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: trg=%h fc=%h want 00 00", bus.trg, bus.fire_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_vec++;
    if ({bus.trg, bus.fire_count} !== {exp_trg, exp_fc}) begin
      n_err++;
      $display("FAIL reset_release: trg=%h fc=%h want %h %h", bus.trg, bus.fire_count, exp_trg, exp_fc);
    end
  endtask

  task automatic test_level_match();
    logic want;
    set_cfg(8'h01, 8'h01, 8'h00, 8'd1, 16'd0, 1'b0);
    bus.probe = 8'h00;
    cycle();
    bus.arm = 1'b1; cycle(); bus.arm = 1'b0;
    bus.probe = 8'h01;
    for (int j = 0; j < 9; j++) begin
      cycle();
      want = (j >= 2) && (j <= 5);
      n_vec++;
      if (bus.trg[0] !== want) begin
        n_err++;
        $display("FAIL level_latency j=%0d: trg0=%b want %b", j, bus.trg[0], want);
      end
      n_vec++;
      if ({bus.trg, bus.fire_count} !== {exp_trg, exp_fc}) begin
        n_err++;
        $display("FAIL level_model j=%0d: trg=%h fc=%h want %h %h", j, bus.trg, bus.fire_count, exp_trg, exp_fc);
      end
    end
    n_vec++;
    if (bus.fire_count !== 8'd1 || bus.trg[3:0] !== 4'b0010) begin
      n_err++;
      $display("FAIL level_end: fc=%0d trg=%h want fc=1 idle", bus.fire_count, bus.trg);
    end
  endtask

  task automatic test_edge_count();
    int rises_early, rises, mcyc;
    logic prev;
    set_cfg(8'h01, 8'h01, 8'h01, 8'd3, 16'd0, 1'b0);
    bus.probe = 8'h00;
    cycle(); cycle();
    bus.arm = 1'b1; cycle(); bus.arm = 1'b0;
    prev = 1'b0; rises = 0;
    for (int t = 0; t < 6; t++) begin
      bus.probe = (t % 2 == 0) ? 8'h01 : 8'h00;
      cycle();
      if (bus.trg[0] && !prev) rises++;
      prev = bus.trg[0];
      n_vec++;
      if ({bus.trg, bus.fire_count} !== {exp_trg, exp_fc}) begin
        n_err++;
        $display("FAIL edge_model t=%0d: trg=%h fc=%h want %h %h", t, bus.trg, bus.fire_count, exp_trg, exp_fc);
      end
    end
    rises_early = rises;
    for (int t = 0; t < 8; t++) begin
      cycle();
      if (bus.trg[0] && !prev) rises++;
      prev = bus.trg[0];
    end
    n_vec++;
    if (rises_early !== 0 || rises !== 1 || bus.fire_count !== 8'd1) begin
      n_err++;
      $display("FAIL edge_third: early=%0d rises=%0d fc=%0d want 0 1 1", rises_early, rises, bus.fire_count);
    end
    // A constant level after one transition gives a single match_q cycle
    mcyc = 0;
    bus.probe = 8'h01;
    for (int t = 0; t < 6; t++) begin
      cycle();
      if (bus.trg[1]) mcyc++;
    end
    n_vec++;
    if (mcyc !== 1) begin
      n_err++;
      $display("FAIL edge_single_match: cycles=%0d want 1", mcyc);
    end
  endtask

  task automatic test_holdoff_rearm();
    int rise_at[$];
    int hold_cyc;
    logic prev;
    set_cfg(8'h01, 8'h01, 8'h00, 8'd1, 16'd10, 1'b1);
    bus.probe = 8'h01;
    cycle();
    bus.arm = 1'b1; cycle(); bus.arm = 1'b0;
    prev = 1'b0; hold_cyc = 0;
    for (int c = 0; c < 70; c++) begin
      cycle();
      if (bus.trg[0] && !prev) rise_at.push_back(c);
      prev = bus.trg[0];
      if (rise_at.size() == 1 && bus.trg[3]) hold_cyc++;
      n_vec++;
      if ({bus.trg, bus.fire_count} !== {exp_trg, exp_fc}) begin
        n_err++;
        $display("FAIL holdoff_model c=%0d: trg=%h fc=%h want %h %h", c, bus.trg, bus.fire_count, exp_trg, exp_fc);
      end
    end
    n_vec++;
    if (rise_at.size() < 3 || hold_cyc !== 10) begin
      n_err++;
      $display("FAIL holdoff_count: fires=%0d hold=%0d want >=3 10", rise_at.size(), hold_cyc);
    end
    for (int i = 1; i < rise_at.size(); i++) begin
      n_vec++;
      if (rise_at[i] - rise_at[i-1] !== 16) begin
        n_err++;
        $display("FAIL holdoff_period %0d: got %0d want 16", i, rise_at[i] - rise_at[i-1]);
      end
    end
    bus.disarm = 1'b1; cycle(); bus.disarm = 1'b0;
    n_vec++;
    if ((bus.trg & 8'h0D) !== 8'h00) begin
      n_err++;
      $display("FAIL holdoff_disarm: trg=%h want fsm bits 0", bus.trg);
    end
  endtask

  task automatic test_priority_empty();
    bus.arm = 1'b1; bus.disarm = 1'b1; cycle();
    bus.arm = 1'b0; bus.disarm = 1'b0;
    n_vec++;
    if (bus.trg[2] !== 1'b0 || {bus.trg, bus.fire_count} !== {exp_trg, exp_fc}) begin
      n_err++;
      $display("FAIL prio_arm_disarm: trg=%h want armed=0 model %h", bus.trg, exp_trg);
    end
    set_cfg(8'h00, 8'(($urandom)), 8'h00, 8'd1, 16'd0, 1'b1);
    bus.arm = 1'b1; cycle(); bus.arm = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.probe = 8'($urandom);
      cycle();
      n_vec++;
      if (bus.trg[1:0] !== 2'b00 || {bus.trg, bus.fire_count} !== {exp_trg, exp_fc}) begin
        n_err++;
        $display("FAIL empty_mask c=%0d: trg=%h fc=%h want %h %h", c, bus.trg, bus.fire_count, exp_trg, exp_fc);
      end
    end
    bus.disarm = 1'b1; cycle(); bus.disarm = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      set_cfg(($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom_range(0, 3)), 16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      bus.arm = 1'b1; cycle(); bus.arm = 1'b0;
      for (int c = 0; c < 60; c++) begin
        bus.probe  = ($urandom_range(0, 1) == 1) ? bus.pattern : 8'($urandom);
        bus.disarm = ($urandom_range(0, 39) == 0);
        bus.arm    = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 19) == 0) bus.auto_rearm = ~bus.auto_rearm;
        cycle();
        n_vec++;
        if ({bus.trg, bus.fire_count} !== {exp_trg, exp_fc}) begin
          n_err++;
          $display("FAIL random r=%0d c=%0d: trg=%h fc=%h want %h %h", r, c, bus.trg, bus.fire_count, exp_trg, exp_fc);
        end
      end
      bus.arm = 1'b0;
      bus.disarm = 1'b1; cycle(); bus.disarm = 1'b0;
    end
  endtask

  task automatic test_reset_mid_fire();
    int waited;
    set_cfg(8'h01, 8'h01, 8'h00, 8'd1, 16'd0, 1'b0);
    bus.probe = 8'h01;
    bus.arm = 1'b1; cycle(); bus.arm = 1'b0;
    waited = 0;
    while (bus.trg[0] !== 1'b1 && waited < 10) begin
      cycle();
      waited++;
    end
    n_vec++;
    if (bus.trg[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midfire_reach: trg0=%b want 1 within 10 cycles", bus.trg[0]);
    end
    cycle();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if (bus.trg !== 8'h00 || bus.fire_count !== 8'h00) begin
      n_err++;
      $display("FAIL midfire_async: trg=%h fc=%h want 00 00", bus.trg, bus.fire_count);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.arm = 1'b1; cycle(); bus.arm = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      n_vec++;
      if ({bus.trg, bus.fire_count} !== {exp_trg, exp_fc}) begin
        n_err++;
        $display("FAIL midfire_restart c=%0d: trg=%h fc=%h want %h %h", c, bus.trg, bus.fire_count, exp_trg, exp_fc);
      end
    end
    n_vec++;
    if (bus.fire_count !== 8'd1) begin
      n_err++;
      $display("FAIL midfire_count: fc=%0d want 1", bus.fire_count);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_level_match();
    test_edge_count();
    test_holdoff_rearm();
    test_priority_empty();
    test_random();
    test_reset_mid_fire();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dbg_trig_gen.md
# dbg_trig_gen

Debug trigger conditioner that sits directly upstream of the ILA debug core. It samples an 8-bit probe bus from the design, evaluates a masked level/edge pattern match, and counts qualifying matches. An arm/fire/hold-off state machine then drives the 8-bit `trg` vector into the ILA's TRIG0 port, so the ILA triggers on one clean, stretched pulse instead of raw glitchy signals.

## Interface
- `STRETCH`, 4: cycles `trg[0]` stays high per fire; legal range 1..255.
- `clk` in 1: single system clock, same clock as the ILA.
- `rst_n` in 1: asynchronous, active-low reset.
- `probe` in 8: design signals under observation, synchronous to `clk`.
- `mask` in 8: 1 = bit participates in the match.
- `pattern` in 8: required value per masked bit.
- `edge_sel` in 8: 1 = bit matches only on a transition into `pattern[i]`; 0 = level match.
- `count_target` in 8: number of matches needed to fire; 0 is treated as 1. Latched on arm.
- `holdoff` in 16: dead-time cycles after a fire. Latched on arm.
- `auto_rearm` in 1: 1 = return to ARMED after hold-off; 0 = return to IDLE.
- `arm` in 1: single-cycle pulse, IDLE→ARMED.
- `disarm` in 1: forces IDLE from any state.
- `trg` out 8: to ILA TRIG0.
  - `[0]` = fire (state FIRE).
  - `[1]` = `match_q`.
  - `[2]` = state ARMED.
  - `[3]` = state HOLDOFF.
  - `[7:4]` = `probe_q[3:0]`.
- `fire_count` out 8: number of fires since the last arm from IDLE; saturates at 255.

## Operation
- **Input stage.**
  - `probe_q` <= `probe`; `probe_d` <= `probe_q`.
  - Per bit `i`:
    - level condition = (`probe_q[i]` == `pattern[i]`).
    - edge condition = level condition && (`probe_d[i]` != `probe_q[i]`).
  - `match` = AND over bits with `mask[i]`=1 of the selected condition.
  - `mask`=0 means `match` is always 0; the block never fires on an empty mask.
  - `match_q` <= `match`.
- **States.** IDLE, ARMED, FIRE, HOLDOFF.
- **IDLE.**
  - `arm` → ARMED.
  - Latch `count_target` (0→1) and `holdoff`.
  - Clear `match_cnt` and `fire_count`.
- **ARMED.**
  - On entry, `match_cnt` is 0.
  - Each cycle with `match_q`=1: if `match_cnt`+1 ≥ target → FIRE, else `match_cnt`++.
  - `arm` while ARMED is ignored; latched values do not change.
- **FIRE.**
  - Stays exactly `STRETCH` cycles, counted by `str_cnt`.
  - On entry, `fire_count` increments (saturating).
  - After `STRETCH` cycles → HOLDOFF if latched `holdoff` ≠ 0.
  - If latched `holdoff` = 0: → ARMED if `auto_rearm`, else → IDLE.
- **HOLDOFF.**
  - Stays exactly latched-`holdoff` cycles.
  - Then → ARMED (with `match_cnt` cleared) if `auto_rearm`, else → IDLE.
- **Matches** during FIRE and HOLDOFF are ignored and not counted.
- **`disarm`** takes priority over every other transition, including a simultaneous `arm`. Next state is IDLE and all counters clear except `fire_count`, which holds.
- **Reset values.** All outputs are 0. State = IDLE. All flops (`probe_q`, `probe_d`, `match_q`, counters, latched values) = 0.
- **Reset mid-FIRE** drops `trg[0]` immediately (asynchronous).
- `auto_rearm` is sampled at the moment of leaving FIRE/HOLDOFF, not latched on arm.

## Timing
- Probe value present at clock edge k:
  - `probe_q` after edge k.
  - `match_q` after edge k+1.
  - FIRE entered after edge k+2.
  - `trg[0]` high starting the cycle after edge k+2.
- Probe-to-trigger latency is therefore 3 clocks.
- `trg` bits are decoded from registered state or taken directly from flops; there is no combinational path from any input to `trg`.
- Back-to-back fire spacing is at least `STRETCH` + `holdoff` + 2 cycles with `auto_rearm`=1 (FIRE, HOLDOFF, ARMED re-entry, next match).
- `arm` and `disarm` act on the edge where they are sampled high; the state changes after that edge.

## Structure
- Package/include `dbg_trig_pkg`:
  - State encoding: one-hot, 4 bits.
  - `trg` bit-index constants: `TRG_FIRE`=0, `TRG_MATCH`=1, `TRG_ARMED`=2, `TRG_HOLD`=3, `TRG_PROBE_LSB`=4.
- Sub-module `dbg_trig_match`: input flops plus per-bit level/edge compare, producing `match_q`.
- Top level `dbg_trig_gen`: FSM, counters, `trg` assembly. Instantiated beside the ICON/ILA pair with `trg` wired to ILA TRIG0.

## Test plan
- **Level match.** Reset; `mask`=0x01, `pattern`=0x01, `edge_sel`=0, `count_target`=1, `holdoff`=0, `auto_rearm`=0; pulse `arm`; drive `probe`=0x01 at edge k → `trg[0]` high 4 cycles starting after edge k+2, then IDLE; `fire_count`=1.
- **Edge count.** `edge_sel`=0x01, `count_target`=3; toggle `probe[0]` 0→1→0 three times → fire on the third rising edge. A constant `probe[0]`=1 gives `match_q` for exactly one cycle.
- **Hold-off and re-arm.** `holdoff`=10, `auto_rearm`=1, continuous match → `trg[0]` high 4 cycles, `trg[3]` high 10 cycles, fires repeat every 16 cycles.
- **Priority and empty mask.** Assert `arm` and `disarm` together in IDLE → stays IDLE. `mask`=0x00 with any probe → never fires; `trg[1]`=0.
- **Reset mid-FIRE.** Drop `rst_n` during FIRE → all `trg` bits and `fire_count` go 0 asynchronously. After release, `arm` restarts the count from 0.
